// File: rtl/bp_fe_ras.sv
// rtl/bp_fe_ras.sv - Circular return address stack with checkpoint and redirect restore
// Fetch speculatively pushes/pops; a backend redirect reloads {cnt, ptr} and replays its own op.
module bp_fe_ras #(
  parameter int vaddr_width_p = 39,
  parameter int ras_depth_p   = 8,
  localparam int ras_ptr_width_lp  = $clog2(ras_depth_p),
  localparam int ras_cnt_width_lp  = $clog2(ras_depth_p + 1),
  localparam int ras_ckpt_width_lp = ras_cnt_width_lp + ras_ptr_width_lp
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         push_v_i,
  input  logic [vaddr_width_p-1:0]     push_addr_i,
  input  logic                         pop_v_i,
  output logic                         top_v_o,
  output logic [vaddr_width_p-1:0]     top_addr_o,
  output logic [ras_ckpt_width_lp-1:0] ckpt_o,
  input  logic                         restore_v_i,
  input  logic [ras_ckpt_width_lp-1:0] restore_ckpt_i,
  input  logic                         restore_push_v_i,
  input  logic                         restore_pop_v_i,
  input  logic [vaddr_width_p-1:0]     restore_addr_i
);

  localparam logic [ras_cnt_width_lp-1:0] depth_cnt_lp = ras_cnt_width_lp'(ras_depth_p);
  localparam logic [ras_cnt_width_lp-1:0] cnt_one_lp   = ras_cnt_width_lp'(1);
  localparam logic [ras_ptr_width_lp-1:0] ptr_one_lp   = ras_ptr_width_lp'(1);

  logic [vaddr_width_p-1:0]    mem_q [ras_depth_p];
  logic [ras_ptr_width_lp-1:0] ptr_q, ptr_d;
  logic [ras_cnt_width_lp-1:0] cnt_q, cnt_d;

  logic [ras_ptr_width_lp-1:0] base_ptr, wr_idx;
  logic [ras_cnt_width_lp-1:0] base_cnt;
  logic                        op_push, op_pop, wr_v;
  logic [vaddr_width_p-1:0]    op_addr;

  assign top_v_o    = (cnt_q != '0);
  assign top_addr_o = top_v_o ? mem_q[ptr_q] : '0;
  assign ckpt_o     = {cnt_q, ptr_q};

  // A redirect discards whatever fetch is doing this cycle.
  always_comb begin
    if (restore_v_i) begin
      {base_cnt, base_ptr} = restore_ckpt_i;
      op_push = restore_push_v_i;
      op_pop  = restore_pop_v_i;
      op_addr = restore_addr_i;
    end else begin
      base_cnt = cnt_q;
      base_ptr = ptr_q;
      op_push  = push_v_i;
      op_pop   = pop_v_i;
      op_addr  = push_addr_i;
    end
  end

  always_comb begin
    ptr_d  = base_ptr;
    cnt_d  = base_cnt;
    wr_v   = 1'b0;
    wr_idx = base_ptr;
    if (op_push && op_pop && (base_cnt != '0)) begin
      // Coroutine jump: replace the top in place.
      wr_v = 1'b1;
    end else if (op_push) begin
      ptr_d  = base_ptr + ptr_one_lp;
      wr_idx = base_ptr + ptr_one_lp;
      wr_v   = 1'b1;
      cnt_d  = (base_cnt == depth_cnt_lp) ? base_cnt : base_cnt + cnt_one_lp;
    end else if (op_pop && (base_cnt != '0)) begin
      ptr_d = base_ptr - ptr_one_lp;
      cnt_d = base_cnt - cnt_one_lp;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < ras_depth_p; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_v) mem_q[wr_idx] <= op_addr;
    end
  end

`ifndef SYNTHESIS
  restore_cnt_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    restore_v_i |-> (restore_ckpt_i[ras_ckpt_width_lp-1 -: ras_cnt_width_lp] <= depth_cnt_lp));
`endif

endmodule

// File: tb/tb_bp_fe_ras.sv
// tb/tb_bp_fe_ras.sv - Scoreboard bench for bp_fe_ras at depth 8
// Expected {top_v, top_addr, ckpt} is queued when stimulus is driven and compared one edge later.
module tb_bp_fe_ras;

  localparam int VW = 39;
  localparam int CKW = 7;

  typedef struct {
    logic          v;
    logic [VW-1:0] addr;
    logic [CKW-1:0] ckpt;
    string         name;
  } exp_t;

  logic           clk_i = 1'b0;
  logic           reset_n_i = 1'b0;
  logic           push_v_i = 1'b0;
  logic [VW-1:0]  push_addr_i = '0;
  logic           pop_v_i = 1'b0;
  logic           top_v_o;
  logic [VW-1:0]  top_addr_o;
  logic [CKW-1:0] ckpt_o;
  logic           restore_v_i = 1'b0;
  logic [CKW-1:0] restore_ckpt_i = '0;
  logic           restore_push_v_i = 1'b0;
  logic           restore_pop_v_i = 1'b0;
  logic [VW-1:0]  restore_addr_i = '0;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;

  bp_fe_ras #(.vaddr_width_p(VW), .ras_depth_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .push_v_i(push_v_i), .push_addr_i(push_addr_i), .pop_v_i(pop_v_i),
    .top_v_o(top_v_o), .top_addr_o(top_addr_o), .ckpt_o(ckpt_o),
    .restore_v_i(restore_v_i), .restore_ckpt_i(restore_ckpt_i),
    .restore_push_v_i(restore_push_v_i), .restore_pop_v_i(restore_pop_v_i),
    .restore_addr_i(restore_addr_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [CKW-1:0] ck(input int cnt, input int ptr);
    logic [3:0] c;
    logic [2:0] p;
    c = 4'(cnt);
    p = 3'(ptr);
    return {c, p};
  endfunction

  task automatic expect_state(input logic v, input logic [VW-1:0] a, input int cnt, input int ptr,
                              input string name);
    exp_t e;
    e.v = v; e.addr = a; e.ckpt = ck(cnt, ptr); e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic push, input logic pop, input logic [VW-1:0] a);
    push_v_i = push; pop_v_i = pop; push_addr_i = a;
    restore_v_i = 1'b0; restore_push_v_i = 1'b0; restore_pop_v_i = 1'b0;
  endtask

  task automatic drive_restore(input logic [CKW-1:0] c, input logic rpush, input logic rpop,
                               input logic [VW-1:0] a);
    restore_v_i = 1'b1; restore_ckpt_i = c;
    restore_push_v_i = rpush; restore_pop_v_i = rpop; restore_addr_i = a;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, '0);
    reset_n_i = 1'b0;
    #2;
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    drive(1'b1, 1'b0, 39'h123);
    #2;
    n_assert++;
    if ({top_v_o, top_addr_o, ckpt_o} !== {1'b0, {VW{1'b0}}, ck(0, 0)}) begin
      n_fail++;
      $display("FAIL reset_now: got v=%0b addr=%0h ckpt=%0h, expected all zero", top_v_o, top_addr_o, ckpt_o);
    end
    cyc();
    n_assert++;
    if ({top_v_o, top_addr_o, ckpt_o} !== {1'b0, {VW{1'b0}}, ck(0, 0)}) begin
      n_fail++;
      $display("FAIL reset_held: got v=%0b addr=%0h ckpt=%0h, expected all zero", top_v_o, top_addr_o, ckpt_o);
    end
    apply_reset();
  endtask

  task automatic test_push_pop();
    exp_t e;
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 3) begin
        drive(1'b1, 1'b0, 39'(i * 'h100));
        expect_state(1'b1, 39'(i * 'h100), i, i, $sformatf("push_%0d", i));
      end else begin
        drive(1'b0, 1'b1, '0);
        expect_state(i != 6, 39'((6 - i) * 'h100), 6 - i, 6 - i, $sformatf("pop_%0d", i - 3));
      end
      if (i == 2) begin
        n_assert++;
        if (ckpt_o !== ck(1, 1)) begin
          n_fail++;
          $display("FAIL ckpt_pre_op: got %0h, expected %0h", ckpt_o, ck(1, 1));
        end
      end
      cyc();
      e = exp_q.pop_front();
      n_assert++;
      if ({top_v_o, top_addr_o, ckpt_o} !== {e.v, e.addr, e.ckpt}) begin
        n_fail++;
        $display("FAIL %s: got v=%0b addr=%0h ckpt=%0h, expected v=%0b addr=%0h ckpt=%0h",
                 e.name, top_v_o, top_addr_o, ckpt_o, e.v, e.addr, e.ckpt);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0, 39'(i * 'h10));
      expect_state(1'b1, 39'(i * 'h10), (i > 8) ? 8 : i, i % 8, $sformatf("ovf_push_%0d", i));
      cyc();
      e = exp_q.pop_front();
      n_assert++;
      if ({top_v_o, top_addr_o, ckpt_o} !== {e.v, e.addr, e.ckpt}) begin
        n_fail++;
        $display("FAIL %s: got v=%0b addr=%0h ckpt=%0h, expected v=%0b addr=%0h ckpt=%0h",
                 e.name, top_v_o, top_addr_o, ckpt_o, e.v, e.addr, e.ckpt);
      end
    end
    for (int j = 1; j <= 9; j++) begin
      drive(1'b0, 1'b1, '0);
      if (j <= 8)
        expect_state(j != 8, (j == 8) ? '0 : 39'('h90 - j * 'h10), 8 - j, (9 - j) % 8,
                     $sformatf("ovf_pop_%0d", j));
      else
        expect_state(1'b0, '0, 0, 1, "underflow_pop");
      cyc();
      e = exp_q.pop_front();
      n_assert++;
      if ({top_v_o, top_addr_o, ckpt_o} !== {e.v, e.addr, e.ckpt}) begin
        n_fail++;
        $display("FAIL %s: got v=%0b addr=%0h ckpt=%0h, expected v=%0b addr=%0h ckpt=%0h",
                 e.name, top_v_o, top_addr_o, ckpt_o, e.v, e.addr, e.ckpt);
      end
    end
  endtask

  task automatic test_push_and_pop();
    exp_t e;
    apply_reset();
    drive(1'b1, 1'b0, 39'h100); cyc();
    drive(1'b1, 1'b0, 39'h200); cyc();
    drive(1'b1, 1'b1, 39'h500);
    expect_state(1'b1, 39'h500, 2, 2, "coroutine_nonempty");
    cyc();
    e = exp_q.pop_front();
    n_assert++;
    if ({top_v_o, top_addr_o, ckpt_o} !== {e.v, e.addr, e.ckpt}) begin
      n_fail++;
      $display("FAIL %s: got v=%0b addr=%0h ckpt=%0h, expected v=%0b addr=%0h ckpt=%0h",
               e.name, top_v_o, top_addr_o, ckpt_o, e.v, e.addr, e.ckpt);
    end
    apply_reset();
    drive(1'b1, 1'b1, 39'h500);
    expect_state(1'b1, 39'h500, 1, 1, "coroutine_empty");
    cyc();
    e = exp_q.pop_front();
    n_assert++;
    if ({top_v_o, top_addr_o, ckpt_o} !== {e.v, e.addr, e.ckpt}) begin
      n_fail++;
      $display("FAIL %s: got v=%0b addr=%0h ckpt=%0h, expected v=%0b addr=%0h ckpt=%0h",
               e.name, top_v_o, top_addr_o, ckpt_o, e.v, e.addr, e.ckpt);
    end
  endtask

  task automatic test_restore();
    exp_t e;
    logic [CKW-1:0] saved;
    apply_reset();
    drive(1'b1, 1'b0, 39'h100); cyc();
    drive(1'b1, 1'b0, 39'h200); cyc();
    saved = ck(2, 2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 39'(('hA + i) * 'h100));
      cyc();
    end
    expect_state(1'b1, 39'hC00, 5, 5, "wrong_path");
    e = exp_q.pop_front();
    n_assert++;
    if ({top_v_o, top_addr_o, ckpt_o} !== {e.v, e.addr, e.ckpt}) begin
      n_fail++;
      $display("FAIL %s: got v=%0b addr=%0h ckpt=%0h, expected v=%0b addr=%0h ckpt=%0h",
               e.name, top_v_o, top_addr_o, ckpt_o, e.v, e.addr, e.ckpt);
    end
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          drive(1'b1, 1'b0, 39'h999);
          drive_restore(saved, 1'b0, 1'b0, 39'h0);
          expect_state(1'b1, 39'h200, 2, 2, "restore_priority");
        end
        1: begin
          drive(1'b0, 1'b1, '0);
          drive_restore(saved, 1'b1, 1'b0, 39'h444);
          expect_state(1'b1, 39'h444, 3, 3, "restore_push");
        end
        default: begin
          drive(1'b1, 1'b0, 39'h777);
          drive_restore(saved, 1'b0, 1'b1, 39'h0);
          expect_state(1'b1, 39'h100, 1, 1, "restore_pop");
        end
      endcase
      cyc();
      e = exp_q.pop_front();
      n_assert++;
      if ({top_v_o, top_addr_o, ckpt_o} !== {e.v, e.addr, e.ckpt}) begin
        n_fail++;
        $display("FAIL %s: got v=%0b addr=%0h ckpt=%0h, expected v=%0b addr=%0h ckpt=%0h",
                 e.name, top_v_o, top_addr_o, ckpt_o, e.v, e.addr, e.ckpt);
      end
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    exp_t e;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 39'(i * 'h1000));
      cyc();
    end
    n_assert++;
    if (ckpt_o !== ck(5, 5)) begin
      n_fail++;
      $display("FAIL async_pre: got ckpt=%0h, expected %0h", ckpt_o, ck(5, 5));
    end
    drive(1'b1, 1'b0, 39'h6000);
    #3;
    reset_n_i = 1'b0;
    #1;
    n_assert++;
    if ({top_v_o, top_addr_o, ckpt_o} !== {1'b0, {VW{1'b0}}, ck(0, 0)}) begin
      n_fail++;
      $display("FAIL async_clear: got v=%0b addr=%0h ckpt=%0h, expected all zero", top_v_o, top_addr_o, ckpt_o);
    end
    cyc();
    reset_n_i = 1'b1;
    drive(1'b1, 1'b0, 39'h700);
    expect_state(1'b1, 39'h700, 1, 1, "post_reset_push");
    cyc();
    e = exp_q.pop_front();
    n_assert++;
    if ({top_v_o, top_addr_o, ckpt_o} !== {e.v, e.addr, e.ckpt}) begin
      n_fail++;
      $display("FAIL %s: got v=%0b addr=%0h ckpt=%0h, expected v=%0b addr=%0h ckpt=%0h",
               e.name, top_v_o, top_addr_o, ckpt_o, e.v, e.addr, e.ckpt);
    end
    drive(1'b0, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_push_and_pop();
    test_restore();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_ras.md
# bp_fe_ras

Parametrised multi-entry return address stack (RAS) for the fetch front end, replacing the single-register return address in PC generation. Calls push the return address and returns pop it. PC generation checkpoints the stack state into branch metadata and restores it on a backend redirect, then replays the redirected instruction's own call/return effect. The stack is a circular buffer, so overflow overwrites the oldest entry instead of stalling.

## Interface
- vaddr_width_p, 39, virtual address width of stored return addresses
- ras_depth_p, 8, number of entries; power of two, 2..64
- ras_ptr_width_lp, $clog2(ras_depth_p), top-of-stack pointer width (derived)
- ras_cnt_width_lp, $clog2(ras_depth_p+1), occupancy count width (derived)
- ras_ckpt_width_lp, ras_cnt_width_lp+ras_ptr_width_lp, checkpoint width (derived)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- reset_n_i  in  1  reset; asynchronous, active-low
- push_v_i  in  1  speculative push (call scanned at fetch)
- push_addr_i  in  vaddr_width_p  return address to push
- pop_v_i  in  1  speculative pop (return scanned at fetch)
- top_v_o  out  1  stack non-empty
- top_addr_o  out  vaddr_width_p  entry at top of stack; 0 when empty
- ckpt_o  out  ras_ckpt_width_lp  current {count, ptr}, carried in branch metadata
- restore_v_i  in  1  backend redirect; restore from restore_ckpt_i
- restore_ckpt_i  in  ras_ckpt_width_lp  checkpoint captured with the redirected instruction
- restore_push_v_i  in  1  redirected instruction is a call; push after restore
- restore_pop_v_i  in  1  redirected instruction is a return; pop after restore
- restore_addr_i  in  vaddr_width_p  return address for restore_push_v_i

## Operation
- State:
  - mem_r[ras_depth_p]: entries
  - ptr_r: index of the top entry
  - cnt_r: valid entries, 0..ras_depth_p
- Outputs are combinational from registered state:
  - top_v_o = (cnt_r != 0)
  - top_addr_o = top_v_o ? mem_r[ptr_r] : 0
  - ckpt_o = {cnt_r, ptr_r}
- Effective operation: on restore_v_i, base = restore_ckpt_i and ops = restore_push/pop/addr; otherwise base = {cnt_r, ptr_r} and ops = push_v_i/pop_v_i/push_addr_i. Restore has absolute priority: fetch push/pop in the same cycle are discarded.
- Apply ops to base (call the base fields cnt and ptr):
  - push only: ptr <= ptr+1 (mod depth); mem[ptr+1] <= addr; cnt <= min(cnt+1, depth). When full, this overwrites the oldest entry.
  - pop only: if cnt != 0, ptr <= ptr-1 (mod depth) and cnt <= cnt-1. If empty, no change (underflow is ignored).
  - push and pop (coroutine jalr): if cnt != 0, mem[ptr] <= addr with ptr and cnt unchanged. If empty, behaves as push only.
  - neither: base is loaded unchanged.
- Restore does not rewrite entries. Slots overwritten by wrong-path pushes stay stale; this is accepted predictor inaccuracy.
- Pointer arithmetic wraps modulo ras_depth_p (natural ptr-width overflow). cnt saturates at ras_depth_p and never goes below 0.
- restore_ckpt_i with cnt > ras_depth_p is illegal; behaviour is undefined and flagged by an assertion.

## Timing
- Reset: while reset_n_i is low, ptr_r=0, cnt_r=0 and all mem_r=0. Outputs immediately read top_v_o=0, top_addr_o=0, ckpt_o=0.
- Reset asserted mid-operation clears state asynchronously; any in-flight push is lost.
- Update latency is 1 cycle: a push sampled at edge N appears on top_addr_o after edge N. There is no same-cycle bypass.
- No handshake: all inputs are valid-only and are consumed every cycle they are asserted. The block never stalls.
- ckpt_o sampled in the same cycle as push_v_i or pop_v_i is the pre-operation state. PC generation stores this value in metadata.

## Test plan
- Push sequence: after reset, push 0x100, 0x200, 0x300 on consecutive cycles -> top_addr_o = 0x300 and cnt = 3. Then three pops -> top reads 0x200, then 0x100, then top_v_o=0 with top_addr_o=0.
- Overflow (depth 8): push 0x10..0x90 (9 pushes) -> cnt saturates at 8 and ptr wraps to 1. Then 8 pops return 0x90..0x20 in order, the stack is empty, and a 9th pop leaves ckpt_o unchanged.
- Push and pop together: top = 0x200, cnt = 2; assert push 0x500 and pop together -> top = 0x500, cnt = 2. On an empty stack the same inputs -> cnt = 1, top = 0x500.
- Restore priority: capture ckpt with cnt = 2 and top = 0x200, then do 3 wrong-path pushes. Assert restore_v_i with that ckpt together with push_v_i (0x999) -> next cycle cnt = 2, top = 0x200, and 0x999 is absent.
- Restore with replay: restore_v_i with restore_push_v_i and restore_addr_i = 0x444 -> cnt = ckpt cnt + 1, top = 0x444. With restore_pop_v_i instead -> cnt = ckpt cnt - 1.
- Async reset: drop reset_n_i mid-cycle while cnt = 5 -> outputs go to 0 before the next edge. Pushes resume cleanly after release.
